// File: rtl/mu0_control.sv
// mu0_control: FSM control unit for the MU0 16-bit CPU.
//
// Sequences FETCH -> EXEC for each instruction and decodes the datapath
// controls (mux selects, register enables, ALU mode) from the state and the
// opcode F. Memory accesses use a Rd/Wr request held until Mem_Ready; an
// optional bus timeout (TIMEOUT > 0) parks the FSM in HALT with a sticky
// Bus_err.
//
// Parameters:
//   TIMEOUT     max consecutive wait cycles per access (0 = no timeout, <=255)
// Optional build macro:
//   MU0_INSTR_COUNT_EN  enables the completed-instruction counter
//                       (Instr_count reads 16'h0000 when undefined)
//
// Ports:
//   Clk, Reset              clock, synchronous active-high reset
//   F[3:0], N, Z            opcode and accumulator flags from the datapath
//   Mem_Ready               memory completed the current Rd/Wr this cycle
//   X_sel, Y_sel, Addr_sel  datapath mux selects
//   PC_En, IR_En, Acc_En    register load enables
//   M[1:0]                  ALU mode (00 Y, 01 X+Y, 10 X+1, 11 X-Y)
//   Rd, Wr                  memory read / write requests
//   Halted, Bus_err         FSM in HALT / sticky bus timeout flag
//   Illegal                 pulse when an opcode 8-F completes execute
//   Instr_count[15:0]       completed instruction count
module mu0_control #(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  F,
  input  logic        N,
  input  logic        Z,
  input  logic        Mem_Ready,
  output logic        X_sel,
  output logic        Y_sel,
  output logic        Addr_sel,
  output logic        PC_En,
  output logic        IR_En,
  output logic        Acc_En,
  output logic [1:0]  M,
  output logic        Rd,
  output logic        Wr,
  output logic        Halted,
  output logic        Bus_err,
  output logic        Illegal,
  output logic [15:0] Instr_count
);

  localparam int unsigned WAIT_W = 8;
  localparam int unsigned CNT_W  = 16;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  localparam logic [1:0] M_Y   = 2'b00;
  localparam logic [1:0] M_ADD = 2'b01;
  localparam logic [1:0] M_INC = 2'b10;
  localparam logic [1:0] M_SUB = 2'b11;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;

  localparam logic [WAIT_W:0] TIMEOUT_X = (WAIT_W + 1)'(TIMEOUT);

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              bus_err_q, bus_err_d;

  logic access_c;
  logic waiting_c;
  logic timeout_c;

  // A memory access is in progress in FETCH and for opcodes 0-3 in EXEC.
  always_comb begin
    access_c = 1'b0;
    case (state_q)
      ST_FETCH: access_c = 1'b1;
      ST_EXEC:  access_c = (F[3:2] == 2'b00);
      default:  access_c = 1'b0;
    endcase
  end

  assign waiting_c = access_c & ~Mem_Ready;

  // Fires on the wait edge at which the counter would reach TIMEOUT.
  assign timeout_c = (TIMEOUT != 0) && waiting_c &&
                     (({1'b0, wait_cnt_q} + (WAIT_W + 1)'(1)) == TIMEOUT_X);

  // Next-state, wait counter and sticky bus error.
  always_comb begin
    state_d   = state_q;
    bus_err_d = bus_err_q;
    case (state_q)
      ST_FETCH: begin
        if (Mem_Ready) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (F[3])                state_d = ST_FETCH;
        else if (F == OP_STP)    state_d = ST_HALT;
        else if (F[2])           state_d = ST_FETCH;
        else if (Mem_Ready)      state_d = ST_FETCH;
      end
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_FETCH;
    endcase

    if (timeout_c) begin
      state_d   = ST_HALT;
      bus_err_d = 1'b1;
    end

    // Counter restarts on every state change; saturates so it cannot wrap.
    if (state_d != state_q)
      wait_cnt_d = '0;
    else if (waiting_c && (wait_cnt_q != {WAIT_W{1'b1}}))
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    else
      wait_cnt_d = wait_cnt_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_FETCH;
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Combinational output decode; everything except Halted/Bus_err is
  // forced low while Reset is asserted.
  always_comb begin
    X_sel    = 1'b0;
    Y_sel    = 1'b0;
    Addr_sel = 1'b0;
    PC_En    = 1'b0;
    IR_En    = 1'b0;
    Acc_En   = 1'b0;
    M        = M_Y;
    Rd       = 1'b0;
    Wr       = 1'b0;
    Illegal  = 1'b0;
    Halted   = (state_q == ST_HALT);
    Bus_err  = bus_err_q;

    if (!Reset) begin
      case (state_q)
        ST_FETCH: begin
          Rd    = 1'b1;
          X_sel = 1'b1;
          M     = M_INC;
          IR_En = Mem_Ready;
          PC_En = Mem_Ready;
        end
        ST_EXEC: begin
          Addr_sel = 1'b1;
          case (F)
            OP_LDA: begin
              Rd     = 1'b1;
              M      = M_Y;
              Acc_En = Mem_Ready;
            end
            OP_STA: begin
              Wr = 1'b1;
            end
            OP_ADD: begin
              Rd     = 1'b1;
              M      = M_ADD;
              Acc_En = Mem_Ready;
            end
            OP_SUB: begin
              Rd     = 1'b1;
              M      = M_SUB;
              Acc_En = Mem_Ready;
            end
            OP_JMP: begin
              Y_sel = 1'b1;
              PC_En = 1'b1;
            end
            OP_JGE: begin
              Y_sel = 1'b1;
              PC_En = ~N;
            end
            OP_JNE: begin
              Y_sel = 1'b1;
              PC_En = ~Z;
            end
            OP_STP: begin
              // No enables; the FSM moves to HALT.
            end
            default: begin
              Illegal = 1'b1;
            end
          endcase
        end
        default: begin
          // HALT: only Halted/Bus_err are driven.
        end
      endcase
    end
  end

`ifdef MU0_INSTR_COUNT_EN
  logic             leave_exec_c;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;

  // An instruction completes on any EXEC exit other than a timeout.
  assign leave_exec_c = (state_q == ST_EXEC) && (state_d != ST_EXEC) && !timeout_c;

  always_comb begin
    instr_count_d = instr_count_q;
    if (leave_exec_c) instr_count_d = instr_count_q + CNT_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (Reset) instr_count_q <= '0;
    else       instr_count_q <= instr_count_d;
  end

  assign Instr_count = instr_count_q;
`else
  assign Instr_count = CNT_W'(0);
`endif

endmodule

// File: tb/tb_mu0_control.sv
// Testbench for mu0_control: directed per-cycle vectors pushed into a
// scoreboard queue by the stimulus process, checked by a negedge monitor.
module tb_mu0_control;

  logic        Clk;
  logic        Reset;
  logic [3:0]  F;
  logic        N;
  logic        Z;
  logic        Mem_Ready;
  logic        X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En;
  logic [1:0]  M;
  logic        Rd, Wr, Halted, Bus_err, Illegal;
  logic [15:0] Instr_count;

  mu0_control #(.TIMEOUT(4)) dut (
    .Clk(Clk), .Reset(Reset), .F(F), .N(N), .Z(Z), .Mem_Ready(Mem_Ready),
    .X_sel(X_sel), .Y_sel(Y_sel), .Addr_sel(Addr_sel), .PC_En(PC_En),
    .IR_En(IR_En), .Acc_En(Acc_En), .M(M), .Rd(Rd), .Wr(Wr),
    .Halted(Halted), .Bus_err(Bus_err), .Illegal(Illegal),
    .Instr_count(Instr_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Vector bits: {X_sel,Y_sel,Addr_sel,PC_En,IR_En,Acc_En,M[1:0],Rd,Wr,Halted,Bus_err,Illegal}
  localparam logic [12:0] V_ZERO    = 13'b0000000000000;
  localparam logic [12:0] V_FETCH   = 13'b1001101010000;
  localparam logic [12:0] V_FETCH_W = 13'b1000001010000;
  localparam logic [12:0] V_LDA     = 13'b0010010010000;
  localparam logic [12:0] V_LDA_W   = 13'b0010000010000;
  localparam logic [12:0] V_ADD     = 13'b0010010110000;
  localparam logic [12:0] V_SUB     = 13'b0010011110000;
  localparam logic [12:0] V_SUB_W   = 13'b0010001110000;
  localparam logic [12:0] V_STA     = 13'b0010000001000;
  localparam logic [12:0] V_JT      = 13'b0111000000000;
  localparam logic [12:0] V_JNT     = 13'b0110000000000;
  localparam logic [12:0] V_STP     = 13'b0010000000000;
  localparam logic [12:0] V_ILL     = 13'b0010000000001;
  localparam logic [12:0] V_HALT    = 13'b0000000000100;
  localparam logic [12:0] V_HALT_BE = 13'b0000000000110;

  typedef struct packed {
    logic [12:0] vec;
    logic [15:0] ic;
  } exp_t;

  exp_t        exp_q[$];
  string       name_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [15:0] exp_ic   = 16'h0000;

  // Drive one cycle of inputs and queue the outputs expected during it.
  task automatic step(input logic rst, input logic [3:0] f, input logic n,
                      input logic z, input logic mr, input logic [12:0] v,
                      input bit leave, input string nm);
    exp_t e;
    Reset = rst; F = f; N = n; Z = z; Mem_Ready = mr;
    e.vec = v;
`ifdef MU0_INSTR_COUNT_EN
    e.ic = exp_ic;
`else
    e.ic = 16'h0000;
`endif
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge Clk); #1;
    if (leave) exp_ic = exp_ic + 16'd1;
  endtask

  // Two reset edges; the second cycle is checked with Reset still high.
  task automatic do_reset();
    Reset = 1'b1; F = 4'h0; N = 1'b0; Z = 1'b0; Mem_Ready = 1'b1;
    @(posedge Clk); #1;
    exp_ic = 16'h0000;
    step(1'b1, 4'h0, 1'b0, 1'b0, 1'b1, V_ZERO, 1'b0, "reset");
  endtask

  task automatic fetch(input logic [3:0] f, input string nm);
    step(1'b0, f, 1'b0, 1'b0, 1'b1, V_FETCH, 1'b0, nm);
  endtask

  // Scoreboard monitor.
  initial begin
    forever begin
      @(negedge Clk);
      if (exp_q.size() != 0) begin : mon
        exp_t        e;
        string       nm;
        logic [12:0] act;
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, M, Rd, Wr,
               Halted, Bus_err, Illegal};
        n_checks++;
        if (act !== e.vec) begin
          n_fail++;
          $display("FAIL %s: outputs got %b expected %b", nm, act, e.vec);
        end
        n_checks++;
        if (Instr_count !== e.ic) begin
          n_fail++;
          $display("FAIL %s: Instr_count got %0d expected %0d", nm, Instr_count, e.ic);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    fetch(4'h0, "lda_fetch");
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, V_LDA, 1'b1, "lda_exec");
    fetch(4'h2, "add_fetch");
    step(1'b0, 4'h2, 1'b0, 1'b0, 1'b1, V_ADD, 1'b1, "add_exec");
    fetch(4'h3, "sub_fetch");
    step(1'b0, 4'h3, 1'b0, 1'b0, 1'b0, V_SUB_W, 1'b0, "sub_wait");
    step(1'b0, 4'h3, 1'b0, 1'b0, 1'b1, V_SUB, 1'b1, "sub_exec");

    fetch(4'h5, "jge_fetch");
    step(1'b0, 4'h5, 1'b1, 1'b0, 1'b1, V_JNT, 1'b1, "jge_n1");
    fetch(4'h5, "jge_fetch");
    step(1'b0, 4'h5, 1'b0, 1'b0, 1'b1, V_JT, 1'b1, "jge_n0");
    fetch(4'h6, "jne_fetch");
    step(1'b0, 4'h6, 1'b0, 1'b1, 1'b1, V_JNT, 1'b1, "jne_z1");
    fetch(4'h6, "jne_fetch");
    step(1'b0, 4'h6, 1'b1, 1'b0, 1'b0, V_JT, 1'b1, "jne_z0_mr0");

    step(1'b0, 4'h4, 1'b0, 1'b0, 1'b0, V_FETCH_W, 1'b0, "fetch_wait1");
    step(1'b0, 4'h4, 1'b0, 1'b0, 1'b0, V_FETCH_W, 1'b0, "fetch_wait2");
    fetch(4'h4, "fetch_done");
    step(1'b0, 4'h4, 1'b0, 1'b0, 1'b0, V_JT, 1'b1, "jmp_mr0");

    fetch(4'h1, "sta_fetch");
    for (int i = 0; i < 3; i++)
      step(1'b0, 4'h1, 1'b0, 1'b0, 1'b0, V_STA, 1'b0, "sta_wait");
    step(1'b0, 4'h1, 1'b0, 1'b0, 1'b1, V_STA, 1'b1, "sta_done");

    fetch(4'h9, "ill_fetch");
    step(1'b0, 4'h9, 1'b0, 1'b0, 1'b1, V_ILL, 1'b1, "illegal");
    fetch(4'h7, "post_illegal_fetch");
    step(1'b0, 4'h7, 1'b0, 1'b0, 1'b1, V_STP, 1'b1, "stp_exec");
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, V_HALT, 1'b0, "halt1");
    step(1'b0, 4'h3, 1'b1, 1'b1, 1'b1, V_HALT, 1'b0, "halt2");
    step(1'b0, 4'h4, 1'b0, 1'b0, 1'b0, V_HALT, 1'b0, "halt3");

    // Five-instruction program: LDA, ADD, STA, JMP, STP.
    do_reset();
    fetch(4'h0, "p_lda_f");
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, V_LDA, 1'b1, "p_lda");
    fetch(4'h2, "p_add_f");
    step(1'b0, 4'h2, 1'b0, 1'b0, 1'b1, V_ADD, 1'b1, "p_add");
    fetch(4'h1, "p_sta_f");
    step(1'b0, 4'h1, 1'b0, 1'b0, 1'b1, V_STA, 1'b1, "p_sta");
    fetch(4'h4, "p_jmp_f");
    step(1'b0, 4'h4, 1'b0, 1'b0, 1'b1, V_JT, 1'b1, "p_jmp");
    fetch(4'h7, "p_stp_f");
    step(1'b0, 4'h7, 1'b0, 1'b0, 1'b1, V_STP, 1'b1, "p_stp");
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, V_HALT, 1'b0, "p_halt_count");

    // Fetch timeout after four wait cycles.
    do_reset();
    for (int i = 0; i < 4; i++)
      step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, V_FETCH_W, 1'b0, "to_fetch_wait");
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, V_HALT_BE, 1'b0, "to_fetch_halt");
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, V_HALT_BE, 1'b0, "to_fetch_sticky");

    // Execute timeout: no instruction counted.
    do_reset();
    fetch(4'h0, "to_exec_fetch");
    for (int i = 0; i < 4; i++)
      step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, V_LDA_W, 1'b0, "to_exec_wait");
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, V_HALT_BE, 1'b0, "to_exec_halt");

    do_reset();
    fetch(4'h0, "post_to_fetch");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge Clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
